// File: rtl/modem_ctrl.sv
// modem_ctrl: half-duplex MSK link controller metering TX bits into the coder
// and moving CDR-recovered RX bits into outFIFO.
module modem_ctrl #(
    parameter int LEN_W = 8,
    parameter int FLUSH_CYCLES = 16,
    parameter int RX_TIMEOUT = 1024
) (
    input  logic             inClock,
    input  logic             inReset,
    input  logic             inTxRequest,
    input  logic [LEN_W-1:0] inTxLength,
    input  logic             inRxRequest,
    input  logic             inAbort,
    input  logic             inFifoEmpty,
    output logic             outFifoReadEnable,
    input  logic             inCoderReady,
    output logic             outCoderEmpty,
    output logic             outRxEnable,
    input  logic             inCdrFlag,
    input  logic             inCdrData,
    input  logic             inOutFifoFull,
    output logic             outOutFifoWriteEnable,
    output logic             outOutFifoData,
    output logic [LEN_W-1:0] outRxCount,
    output logic             outUnderrun,
    output logic             outOverflow,
    output logic             outTxDone,
    output logic             outRxDone,
    output logic [1:0]       outState
);
    localparam int FW = $clog2(FLUSH_CYCLES + 1);
    localparam int TW = $clog2(RX_TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, TX_RUN, TX_FLUSH, RX_RUN} state_t;
    state_t state;
    logic [LEN_W-1:0] remaining;
    logic [FW-1:0] flushCount;
    logic [TW-1:0] idleCount;
    logic txRun, rxEnd;
    assign txRun = state == TX_RUN;
    assign outFifoReadEnable = txRun & inCoderReady & ~inFifoEmpty & ~inAbort;
    assign outCoderEmpty = txRun ? inFifoEmpty : 1'b1;
    assign outState = state;
    // idleCount reaches RX_TIMEOUT-1 on this cycle's increment
    assign rxEnd = ~inRxRequest | (~inCdrFlag & (idleCount == TW'(RX_TIMEOUT - 2)));
    always_ff @(posedge inClock) begin
        if (inReset) begin
            state <= IDLE;
            remaining <= '0;
            flushCount <= '0;
            idleCount <= '0;
            outRxEnable <= 1'b0;
            outOutFifoWriteEnable <= 1'b0;
            outOutFifoData <= 1'b0;
            outRxCount <= '0;
            outUnderrun <= 1'b0;
            outOverflow <= 1'b0;
            outTxDone <= 1'b0;
            outRxDone <= 1'b0;
        end else begin
            outTxDone <= 1'b0;
            outRxDone <= 1'b0;
            outOutFifoWriteEnable <= 1'b0;
            if (inAbort) begin
                state <= IDLE;
                outRxEnable <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (inTxRequest) begin
                            if (inTxLength == '0) outTxDone <= 1'b1;
                            else begin
                                remaining <= inTxLength;
                                outUnderrun <= 1'b0;
                                state <= TX_RUN;
                            end
                        end else if (inRxRequest) begin
                            outRxCount <= '0;
                            outOverflow <= 1'b0;
                            outRxEnable <= 1'b1;
                            idleCount <= '0;
                            state <= RX_RUN;
                        end
                    end
                    TX_RUN: begin
                        if (inCoderReady & inFifoEmpty) outUnderrun <= 1'b1;
                        if (outFifoReadEnable) begin
                            remaining <= remaining - 1'b1;
                            if (remaining == LEN_W'(1)) begin
                                flushCount <= '0;
                                state <= TX_FLUSH;
                            end
                        end
                    end
                    TX_FLUSH: begin
                        flushCount <= flushCount + 1'b1;
                        if (flushCount == FW'(FLUSH_CYCLES - 1)) begin
                            state <= IDLE;
                            outTxDone <= 1'b1;
                        end
                    end
                    RX_RUN: begin
                        idleCount <= inCdrFlag ? '0 : idleCount + 1'b1;
                        if (inCdrFlag & ~inOutFifoFull) begin
                            outOutFifoWriteEnable <= 1'b1;
                            outOutFifoData <= inCdrData;
                            if (~&outRxCount) outRxCount <= outRxCount + 1'b1;
                        end
                        if (inCdrFlag & inOutFifoFull) outOverflow <= 1'b1;
                        if (rxEnd) begin
                            state <= IDLE;
                            outRxEnable <= 1'b0;
                            outRxDone <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_modem_ctrl.sv
// tb_modem_ctrl: directed stimulus with a per-cycle behavioural model of the
// controller plus hand-computed literal expectations.
module tb_modem_ctrl;
    localparam int FLUSH = 16;
    localparam int TMO = 1024;
    logic inClock = 0, inReset = 1, inTxRequest = 0, inRxRequest = 0, inAbort = 0;
    logic inFifoEmpty = 1, inCoderReady = 0, inCdrFlag = 0, inCdrData = 0, inOutFifoFull = 0;
    logic [7:0] inTxLength = 0;
    logic outFifoReadEnable, outCoderEmpty, outRxEnable, outOutFifoWriteEnable, outOutFifoData;
    logic outUnderrun, outOverflow, outTxDone, outRxDone;
    logic [7:0] outRxCount;
    logic [1:0] outState;

    modem_ctrl #(.LEN_W(8), .FLUSH_CYCLES(FLUSH), .RX_TIMEOUT(TMO)) dut (
        .inClock(inClock), .inReset(inReset), .inTxRequest(inTxRequest), .inTxLength(inTxLength),
        .inRxRequest(inRxRequest), .inAbort(inAbort), .inFifoEmpty(inFifoEmpty),
        .outFifoReadEnable(outFifoReadEnable), .inCoderReady(inCoderReady),
        .outCoderEmpty(outCoderEmpty), .outRxEnable(outRxEnable), .inCdrFlag(inCdrFlag),
        .inCdrData(inCdrData), .inOutFifoFull(inOutFifoFull),
        .outOutFifoWriteEnable(outOutFifoWriteEnable), .outOutFifoData(outOutFifoData),
        .outRxCount(outRxCount), .outUnderrun(outUnderrun), .outOverflow(outOverflow),
        .outTxDone(outTxDone), .outRxDone(outRxDone), .outState(outState)
    );

    always #5 inClock = ~inClock;

    int total = 0, bad = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: mode 0 idle, 1 sending, 2 flushing, 3 receiving
    int mMode = 0, bitsLeft = 0, flushLeft = 0, quiet = 0, mCount = 0;
    bit mRxEn = 0, mWr = 0, mData = 0, mUnder = 0, mOver = 0, mTxDone = 0, mRxDone = 0;
    always @(posedge inClock) begin
        mTxDone = 0; mRxDone = 0; mWr = 0;
        if (inReset) begin
            mMode = 0; mRxEn = 0; mCount = 0; mUnder = 0; mOver = 0;
        end else if (inAbort) begin
            mMode = 0; mRxEn = 0;
        end else if (mMode == 0) begin
            if (inTxRequest) begin
                if (inTxLength == 0) mTxDone = 1;
                else begin bitsLeft = inTxLength; mUnder = 0; mMode = 1; end
            end else if (inRxRequest) begin
                mCount = 0; mOver = 0; mRxEn = 1; quiet = 0; mMode = 3;
            end
        end else if (mMode == 1) begin
            if (inCoderReady && inFifoEmpty) mUnder = 1;
            if (inCoderReady && !inFifoEmpty) begin
                bitsLeft--;
                if (bitsLeft == 0) begin mMode = 2; flushLeft = FLUSH; end
            end
        end else if (mMode == 2) begin
            flushLeft--;
            if (flushLeft == 0) begin mMode = 0; mTxDone = 1; end
        end else begin
            if (inCdrFlag) begin
                quiet = 0;
                if (inOutFifoFull) mOver = 1;
                else begin mWr = 1; mData = inCdrData; mCount = (mCount < 255) ? mCount + 1 : 255; end
            end else quiet++;
            if (!inRxRequest || quiet == TMO - 1) begin mMode = 0; mRxEn = 0; mRxDone = 1; end
        end
    end

    bit checkOn = 0;
    int cycle = 0, reads = 0, writes = 0, txDones = 0, rxDones = 0;
    int lastRead = 0, txDoneAt = 0, lastFlag = 0, rxDoneAt = 0;
    logic [31:0] wrLog = 0;
    always @(negedge inClock) begin
        cycle++;
        if (checkOn) begin
            chk("state", outState, mMode);
            chk("readEnable", outFifoReadEnable, mMode == 1 && inCoderReady && !inFifoEmpty && !inAbort);
            chk("coderEmpty", outCoderEmpty, mMode == 1 ? inFifoEmpty : 1'b1);
            chk("rxEnable", outRxEnable, mRxEn);
            chk("writeEnable", outOutFifoWriteEnable, mWr);
            if (mWr) chk("writeData", outOutFifoData, mData);
            chk("rxCount", outRxCount, mCount);
            chk("underrun", outUnderrun, mUnder);
            chk("overflow", outOverflow, mOver);
            chk("txDone", outTxDone, mTxDone);
            chk("rxDone", outRxDone, mRxDone);
            if (outFifoReadEnable) begin reads++; lastRead = cycle; end
            if (outOutFifoWriteEnable) begin writes++; wrLog = {wrLog[30:0], outOutFifoData}; end
            if (outTxDone) begin txDones++; txDoneAt = cycle; end
            if (outRxDone) begin rxDones++; rxDoneAt = cycle; end
            if (inCdrFlag && outState == 2'd3) lastFlag = cycle;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge inClock);
        #1;
    endtask

    task automatic pulseReady(input int n, input int gap);
        repeat (n) begin
            inCoderReady = 1; tick(1);
            inCoderReady = 0; tick(gap - 1);
        end
    endtask

    task automatic waitDone(input bit rx, input int limit, input string name);
        int k;
        for (k = 0; k < limit; k++) begin
            if (rx ? outRxDone : outTxDone) break;
            tick(1);
        end
        chk(name, k < limit, 1);
    endtask

    task automatic flag(input bit d, input bit full);
        inCdrFlag = 1; inCdrData = d; inOutFifoFull = full; tick(1);
        inCdrFlag = 0; inOutFifoFull = 0; tick(1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, w0, t0, d0;
        logic [9:0] rxSeq;
        rxSeq = 10'b1011001011;
        tick(1);
        checkOn = 1;
        tick(2);
        chk("resetState", outState, 0);
        chk("resetCoderEmpty", outCoderEmpty, 1);
        chk("resetRxEnable", outRxEnable, 0);
        chk("resetTxDone", outTxDone, 0);
        inReset = 0; tick(2);

        // TX nominal: 5 bits, ready every 4 cycles
        inFifoEmpty = 0; inTxLength = 5; inTxRequest = 1; tick(1);
        inTxRequest = 0; r0 = reads;
        pulseReady(5, 4);
        waitDone(0, 40, "txNominalDone");
        tick(1);
        chk("txNominalReads", reads - r0, 5);
        chk("txFlushSpan", txDoneAt - lastRead, FLUSH + 1);
        chk("txNominalUnderrun", outUnderrun, 0);

        // TX underrun: one bit, FIFO dry, refill
        inTxLength = 3; inTxRequest = 1; tick(1);
        inTxRequest = 0; r0 = reads;
        pulseReady(1, 4);
        inFifoEmpty = 1; inCoderReady = 1; #1;
        chk("underrunCoderEmpty", outCoderEmpty, 1);
        tick(1);
        chk("underrunFlag", outUnderrun, 1);
        inCoderReady = 0; tick(3);
        pulseReady(1, 4);
        inFifoEmpty = 0;
        pulseReady(2, 4);
        waitDone(0, 40, "underrunDone");
        tick(1);
        chk("underrunReads", reads - r0, 3);

        // RX nominal: 10 bits, then request drops
        w0 = writes; inRxRequest = 1; tick(1);
        for (int i = 9; i >= 0; i--) flag(rxSeq[i], 0);
        inRxRequest = 0; tick(1);
        waitDone(1, 10, "rxNominalDone");
        tick(1);
        chk("rxNominalWrites", writes - w0, 10);
        chk("rxNominalData", wrLog[9:0], 10'b1011001011);
        chk("rxNominalCount", outRxCount, 10);
        chk("rxNominalEnable", outRxEnable, 0);

        // RX overflow on flags 3-4 of 6, then timeout
        w0 = writes; inRxRequest = 1; tick(1);
        for (int i = 1; i <= 6; i++) flag(1, i == 3 || i == 4);
        waitDone(1, TMO + 20, "rxTimeoutDone");
        inRxRequest = 0; tick(1);
        chk("rxOvfWrites", writes - w0, 4);
        chk("rxOvfCount", outRxCount, 4);
        chk("rxOvfFlag", outOverflow, 1);
        chk("rxTimeoutSpan", rxDoneAt - lastFlag, TMO);
        tick(2);

        // Priority, then abort mid TX_RUN
        t0 = txDones; inTxLength = 2; inTxRequest = 1; inRxRequest = 1; tick(1);
        inTxRequest = 0; inRxRequest = 0;
        chk("priorityState", outState, 1);
        pulseReady(1, 3);
        r0 = reads; inAbort = 1; inCoderReady = 1; #1;
        chk("abortReadForced", outFifoReadEnable, 0);
        tick(1);
        inAbort = 0; inCoderReady = 0;
        chk("abortState", outState, 0);
        pulseReady(4, 3);
        tick(20);
        chk("abortNoReads", reads - r0, 0);
        chk("abortNoTxDone", txDones - t0, 0);

        // Zero-length TX
        r0 = reads; inTxLength = 0; inTxRequest = 1; tick(1);
        inTxRequest = 0;
        chk("zeroLenDone", outTxDone, 1);
        tick(1);
        chk("zeroLenDoneCleared", outTxDone, 0);
        chk("zeroLenReads", reads - r0, 0);

        // Reset mid RX_RUN
        d0 = rxDones; inRxRequest = 1; tick(1);
        flag(1, 0);
        flag(0, 1);
        chk("preResetCount", outRxCount, 1);
        chk("preResetOverflow", outOverflow, 1);
        inReset = 1; tick(1);
        chk("midResetState", outState, 0);
        chk("midResetCount", outRxCount, 0);
        chk("midResetOverflow", outOverflow, 0);
        inReset = 0; inRxRequest = 0; tick(3);
        chk("midResetNoRxDone", rxDones - d0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/modem_ctrl.md
Name: modem_ctrl

Overview:
Half-duplex link controller for the MSK modem path.
- TX side: meters a programmed number of bits from inFIFO into the MSK coder under the coder's ready handshake, then holds the coder idle for a flush tail.
- RX side: gates the decoder/CORDIC/CDR chain and moves CDR-recovered bits into outFIFO, with overflow and inactivity-timeout handling.
- Sits between the top-level host strobes and the FIFO/coder/CDR datapath, replacing the test-mux direct drive in functional mode.

Parameters:
LEN_W, 8, width of TX bit-length and RX bit-count fields
FLUSH_CYCLES, 16, clock cycles the coder is held empty after the last TX bit
RX_TIMEOUT, 1024, cycles without a CDR flag before RX terminates (must be >= 2)

Ports:
inClock  in  1  system clock, all logic on rising edge
inReset  in  1  synchronous, active-high reset
inTxRequest  in  1  level; start TX frame when sampled in IDLE
inTxLength  in  LEN_W  bits to transmit; latched on TX start
inRxRequest  in  1  level; RX runs while high
inAbort  in  1  return to IDLE next cycle, no done pulse
inFifoEmpty  in  1  inFIFO empty flag
outFifoReadEnable  out  1  inFIFO read strobe (combinational)
inCoderReady  in  1  coder requests next bit
outCoderEmpty  out  1  coder i_empty (combinational)
outRxEnable  out  1  enables decoder/CDR path (registered)
inCdrFlag  in  1  CDR bit-valid strobe
inCdrData  in  1  CDR recovered bit
inOutFifoFull  in  1  outFIFO full flag
outOutFifoWriteEnable  out  1  outFIFO write strobe (registered)
outOutFifoData  out  1  outFIFO write data (registered)
outRxCount  out  LEN_W  bits written this RX frame, saturating
outUnderrun  out  1  sticky: inFIFO empty while coder ready during TX
outOverflow  out  1  sticky: CDR bit dropped because outFIFO full
outTxDone  out  1  one-cycle pulse at end of TX flush
outRxDone  out  1  one-cycle pulse at RX end (timeout or request drop)
outState  out  2  0 IDLE, 1 TX_RUN, 2 TX_FLUSH, 3 RX_RUN

Behaviour:
- Reset: state IDLE.
  - All registered outputs 0, except outCoderEmpty = 1 (combinational from IDLE).
  - Counters and sticky flags cleared.
  - Reset mid-frame discards the frame; no done pulses.
- IDLE:
  - inTxRequest has priority over inRxRequest when both are high.
  - TX start with inTxLength == 0: stay IDLE and pulse outTxDone on the next cycle.
  - TX start with inTxLength != 0: latch remaining = inTxLength, clear outUnderrun, go to TX_RUN.
  - inRxRequest alone: clear outRxCount and outOverflow, set outRxEnable, go to RX_RUN.
- TX_RUN:
  - outFifoReadEnable = inCoderReady & ~inFifoEmpty. Zero-latency handshake; the coder samples FIFO data in the same cycle.
  - outCoderEmpty = inFifoEmpty.
  - Each read decrements remaining. The read with remaining == 1 moves the FSM to TX_FLUSH.
  - inCoderReady & inFifoEmpty: set outUnderrun, no decrement, stay in TX_RUN.
  - inTxRequest is ignored after start.
- TX_FLUSH:
  - outCoderEmpty = 1, outFifoReadEnable = 0.
  - Counts FLUSH_CYCLES cycles, then goes to IDLE.
  - outTxDone pulses in the first IDLE cycle.
- RX_RUN:
  - outRxEnable = 1.
  - On inCdrFlag with ~inOutFifoFull: next cycle outOutFifoWriteEnable = 1 and outOutFifoData = inCdrData (1-cycle latency). outRxCount increments, saturating at all-ones.
  - On inCdrFlag with inOutFifoFull: no write, set outOverflow, count unchanged.
  - Inactivity counter clears on every inCdrFlag and increments otherwise. Reaching RX_TIMEOUT-1 ends the frame.
  - inRxRequest low also ends the frame.
  - Frame end: next state IDLE, outRxEnable = 0, outRxDone pulses 1 cycle.
  - A flag in the terminating cycle is still written.
- inAbort:
  - From any state, next state IDLE. Read/write strobes are forced 0 in the abort cycle; the registered write then stays 0 in the following cycle.
  - No done pulse. Sticky flags and outRxCount hold their values.
- outCoderEmpty = 1 in every state except TX_RUN.
- outFifoReadEnable = 0 outside TX_RUN.

Test Plan:
- TX nominal: inTxLength = 5, FIFO non-empty, inCoderReady pulsed every 4 cycles. Expect exactly 5 read strobes, each coincident with ready, then TX_FLUSH for 16 cycles, outTxDone high one cycle, outUnderrun = 0.
- TX underrun: inTxLength = 3, FIFO empties after 1 bit, ready keeps pulsing. Expect outCoderEmpty = 1 and outUnderrun = 1. After refill, 2 more reads, then flush and outTxDone.
- RX nominal: 10 CDR flags with data 1,0,1,1,0,0,1,0,1,1, then inRxRequest drops. Expect 10 writes with matching data, each 1 cycle after its flag, outRxCount = 10, outRxDone pulse, outRxEnable = 0.
- RX overflow and timeout: inOutFifoFull = 1 during flags 3–4 of 6, then no flags. Expect 4 writes, outOverflow = 1, outRxDone exactly RX_TIMEOUT cycles after the last flag.
- Priority and zero length: inTxRequest and inRxRequest rise together. Expect TX_RUN. Separately, inTxLength = 0 gives outTxDone on the next cycle with no reads.
- Abort/reset: inAbort in mid TX_RUN returns to IDLE with no outTxDone and no further reads. inReset mid RX_RUN clears outRxCount and outOverflow, and outState = 0 on the next cycle.
